// File: rtl/morty_ex_pkg.sv
// Shared opcodes, FSM states and trap codes for the execute stage.
// Consumed by ex_stage_pipe and ex_muldiv.
package morty_ex_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SLL  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SRA  = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    EX_IDLE,
    EX_BUSY,
    EX_DONE
  } ex_state_e;

  localparam logic [3:0] TRAP_ILLEGAL = 4'd2;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV-M unit: shift-add multiply, restoring divide,
// one bit per cycle on magnitudes with sign fixup at the end.
module ex_muldiv
  import morty_ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [2:0]      op_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q, lo_q, dvs_q, a_q;
  logic [2:0]      op_q;
  logic            neg_q, neg_r_q, div0_q;

  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN:0]   msum, rsh, dif;

  assign a_sgn = (op_i == MD_MULH) || (op_i == MD_MULHSU)
              || (op_i == MD_DIV) || (op_i == MD_REM);
  assign b_sgn = (op_i == MD_MULH) || (op_i == MD_DIV)
              || (op_i == MD_REM);
  assign a_neg = a_sgn & a_i[XLEN-1];
  assign b_neg = b_sgn & b_i[XLEN-1];
  assign a_abs = a_neg ? -a_i : a_i;
  assign b_abs = b_neg ? -b_i : b_i;

  assign msum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
  assign rsh  = {acc_q, lo_q[XLEN-1]};
  assign dif  = rsh - {1'b0, dvs_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      div0_q  <= 1'b0;
    end else if (kill_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q   <= CW'(XLEN);
      acc_q   <= '0;
      lo_q    <= a_abs;
      dvs_q   <= b_abs;
      a_q     <= a_i;
      op_q    <= op_i;
      neg_q   <= a_neg ^ b_neg;
      neg_r_q <= a_neg;
      div0_q  <= (b_i == '0);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      if (op_q[2]) begin
        if (!dif[XLEN]) begin
          acc_q <= dif[XLEN-1:0];
          lo_q  <= {lo_q[XLEN-2:0], 1'b1};
        end else begin
          acc_q <= rsh[XLEN-1:0];
          lo_q  <= {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        acc_q <= msum[XLEN:1];
        lo_q  <= {msum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  // Asserted on the final iteration; result_o is valid from the next cycle.
  assign done_o = (cnt_q == CW'(1));

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    prod     = neg_q ? -{acc_q, lo_q} : {acc_q, lo_q};
    quo      = neg_q ? -lo_q : lo_q;
    rem      = neg_r_q ? -acc_q : acc_q;
    result_o = '0;
    unique case (op_q)
      MD_MUL:    result_o = prod[XLEN-1:0];
      MD_MULH,
      MD_MULHSU,
      MD_MULHU:  result_o = prod[2*XLEN-1:XLEN];
      MD_DIV,
      MD_DIVU:   result_o = div0_q ? '1 : quo;
      default:   result_o = div0_q ? a_q : rem;
    endcase
  end

endmodule

// File: rtl/ex_stage_pipe.sv
// Registered execute stage with ALU, optional iterative RV-M unit
// (enabled by MORTY_EX_MULDIV_EN) and valid/ready on both sides.
module ex_stage_pipe
  import morty_ex_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic [3:0]      alu_op_i,
  input  logic            is_md_i,
  input  logic [2:0]      md_op_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc4_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] csr_data_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [3:0]      trap_code_i,
  input  logic            is_trap_i,
  input  logic            is_rs0_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc4_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] csr_data_o,
  output logic [11:0]     csr_addr_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [3:0]      trap_code_o,
  output logic            is_trap_o,
  output logic            is_rs0_o
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [4:0]      rd;
    logic [XLEN-1:0] csr_data;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] rs2_data;
    logic [3:0]      trap_code;
    logic            is_trap;
    logic            is_rs0;
  } side_t;

  side_t           side_in, nxt_side, out_q;
  logic [XLEN-1:0] alu_res, nxt_res, res_q;
  logic            valid_q, room, accept, drain, alu_load, load;
  logic [SHW-1:0]  shamt;

  always_comb begin
    side_in.pc        = pc_i;
    side_in.pc4       = pc4_i;
    side_in.rd        = rd_i;
    side_in.csr_data  = csr_data_i;
    side_in.csr_addr  = csr_addr_i;
    side_in.rs2_data  = rs2_data_i;
    side_in.trap_code = trap_code_i;
    side_in.is_trap   = is_trap_i;
    side_in.is_rs0    = is_rs0_i;
  end

  assign shamt = src_b_i[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_op_i)
      ALU_ADD:  alu_res = src_a_i + src_b_i;
      ALU_SLL:  alu_res = src_a_i << shamt;
      ALU_SUB:  alu_res = src_a_i - src_b_i;
      ALU_SRA:  alu_res = XLEN'($signed(src_a_i) >>> shamt);
      ALU_XOR:  alu_res = src_a_i ^ src_b_i;
      ALU_SRL:  alu_res = src_a_i >> shamt;
      ALU_OR:   alu_res = src_a_i | src_b_i;
      ALU_AND:  alu_res = src_a_i & src_b_i;
      ALU_SLT:  alu_res = XLEN'($signed(src_a_i) < $signed(src_b_i));
      ALU_SLTU: alu_res = XLEN'(src_a_i < src_b_i);
      default:  alu_res = '0;
    endcase
  end

  assign room   = !valid_q || ready_i;
  assign accept = valid_i && ready_o;
  assign drain  = valid_q && ready_i;

`ifdef MORTY_EX_MULDIV_EN
  ex_state_e       state_q, state_d;
  side_t           side_q;
  logic            md_start, md_done, md_load;
  logic [XLEN-1:0] md_res;

  assign ready_o  = (state_q == EX_IDLE) && room;
  assign md_start = accept && is_md_i && !is_trap_i && !flush_i;
  assign alu_load = accept && !(is_md_i && !is_trap_i);
  assign md_load  = (state_q == EX_DONE) && room;
  assign load     = alu_load || md_load;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EX_IDLE: if (md_start) state_d = EX_BUSY;
      EX_BUSY: if (md_done) state_d = EX_DONE;
      EX_DONE: if (room) state_d = EX_IDLE;
      default: state_d = EX_IDLE;
    endcase
    if (flush_i) state_d = EX_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EX_IDLE;
      side_q  <= '0;
    end else begin
      state_q <= state_d;
      if (md_start) side_q <= side_in;
    end
  end

  ex_muldiv #(
    .XLEN(XLEN)
  ) u_muldiv (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (md_start),
    .kill_i   (flush_i),
    .a_i      (src_a_i),
    .b_i      (src_b_i),
    .op_i     (md_op_i),
    .done_o   (md_done),
    .result_o (md_res)
  );

  always_comb begin
    nxt_side = side_in;
    nxt_res  = is_trap_i ? '0 : alu_res;
    if (md_load) begin
      nxt_side = side_q;
      nxt_res  = md_res;
    end
  end
`else
  logic unused_md_op;

  assign unused_md_op = ^md_op_i;
  assign ready_o      = room;
  assign alu_load     = accept;
  assign load         = alu_load;

  // Without the MDU, an RV-M op retires as an illegal-instruction trap.
  always_comb begin
    nxt_side = side_in;
    nxt_res  = is_trap_i ? '0 : alu_res;
    if (is_md_i) begin
      nxt_res           = '0;
      nxt_side.is_trap  = 1'b1;
      nxt_side.trap_code = is_trap_i ? trap_code_i : TRAP_ILLEGAL;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      out_q   <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      res_q   <= nxt_res;
      out_q   <= nxt_side;
    end else if (drain) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o     = valid_q;
  assign result_o    = res_q;
  assign pc_o        = out_q.pc;
  assign pc4_o       = out_q.pc4;
  assign rd_o        = out_q.rd;
  assign csr_data_o  = out_q.csr_data;
  assign csr_addr_o  = out_q.csr_addr;
  assign rs2_data_o  = out_q.rs2_data;
  assign trap_code_o = out_q.trap_code;
  assign is_trap_o   = out_q.is_trap;
  assign is_rs0_o    = out_q.is_rs0;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Randomised self-checking bench for ex_stage_pipe (XLEN=32);
// RV-M scenarios follow MORTY_EX_MULDIV_EN.
module tb_ex_stage_pipe;

  localparam int XLEN = 32;
  localparam int SBW  = 4 * XLEN + 23;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            flush_i = 1'b0;
  logic            valid_i = 1'b0;
  logic            ready_o;
  logic [XLEN-1:0] src_a_i = '0;
  logic [XLEN-1:0] src_b_i = '0;
  logic [3:0]      alu_op_i = '0;
  logic            is_md_i = 1'b0;
  logic [2:0]      md_op_i = '0;
  logic [XLEN-1:0] pc_i = '0;
  logic [XLEN-1:0] pc4_i = '0;
  logic [4:0]      rd_i = '0;
  logic [XLEN-1:0] csr_data_i = '0;
  logic [11:0]     csr_addr_i = '0;
  logic [XLEN-1:0] rs2_data_i = '0;
  logic [3:0]      trap_code_i = '0;
  logic            is_trap_i = 1'b0;
  logic            is_rs0_i = 1'b0;
  logic            valid_o;
  logic            ready_i = 1'b1;
  logic [XLEN-1:0] result_o;
  logic [XLEN-1:0] pc_o, pc4_o, csr_data_o, rs2_data_o;
  logic [4:0]      rd_o;
  logic [11:0]     csr_addr_o;
  logic [3:0]      trap_code_o;
  logic            is_trap_o, is_rs0_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_stage_pipe #(.XLEN(XLEN)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .src_a_i(src_a_i), .src_b_i(src_b_i),
    .alu_op_i(alu_op_i), .is_md_i(is_md_i), .md_op_i(md_op_i),
    .pc_i(pc_i), .pc4_i(pc4_i), .rd_i(rd_i),
    .csr_data_i(csr_data_i), .csr_addr_i(csr_addr_i),
    .rs2_data_i(rs2_data_i), .trap_code_i(trap_code_i),
    .is_trap_i(is_trap_i), .is_rs0_i(is_rs0_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .pc_o(pc_o), .pc4_o(pc4_o), .rd_o(rd_o),
    .csr_data_o(csr_data_o), .csr_addr_o(csr_addr_o),
    .rs2_data_o(rs2_data_o), .trap_code_o(trap_code_o),
    .is_trap_o(is_trap_o), .is_rs0_o(is_rs0_o)
  );

  function automatic logic [SBW-1:0] sb_out();
    return {pc_o, pc4_o, rd_o, csr_data_o, csr_addr_o,
            rs2_data_o, trap_code_o, is_trap_o, is_rs0_o};
  endfunction

  function automatic logic [SBW-1:0] sb_in();
    return {pc_i, pc4_i, rd_i, csr_data_i, csr_addr_i,
            rs2_data_i, trap_code_i, is_trap_i, is_rs0_i};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    sh = int'(b % 32);
    case (op)
      4'd0: return 32'(ua + ub);
      4'd1: return 32'(ua * (longint'(1) << sh));
      4'd2: return 32'(ua - ub);
      4'd3: return 32'(sa >>> sh);
      4'd4: return a ^ b;
      4'd5: return 32'(ua / (longint'(1) << sh));
      4'd6: return a | b;
      4'd7: return a & b;
      4'd8: return (sa < sb) ? 32'd1 : 32'd0;
      4'd9: return (ua < ub) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'd6: return (b == 0) ? a : 32'(sa % sb);
      default: return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic md,
                       input logic [2:0] mop, input logic trap,
                       input logic [3:0] tc);
    @(negedge clk);
    valid_i     = 1'b1;
    src_a_i     = a;
    src_b_i     = b;
    alu_op_i    = op;
    is_md_i     = md;
    md_op_i     = mop;
    is_trap_i   = trap;
    trap_code_i = tc;
    pc_i        = $urandom;
    pc4_i       = pc_i + 32'd4;
    rd_i        = 5'($urandom);
    csr_data_i  = $urandom;
    csr_addr_i  = 12'($urandom);
    rs2_data_i  = $urandom;
    is_rs0_i    = 1'($urandom);
  endtask

  task automatic wait_valid(output int cyc, output bit rdy_bad);
    cyc = 0;
    rdy_bad = 1'b0;
    while (!valid_o && cyc < 100) begin
      if (ready_o !== 1'b0) rdy_bad = 1'b1;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_err++; $display("FAIL reset valid_o: got %b want 0", valid_o);
    end
    n_cmp++;
    if (result_o !== '0) begin
      n_err++; $display("FAIL reset result_o: got %h want 0", result_o);
    end
    n_cmp++;
    if (sb_out() !== '0) begin
      n_err++; $display("FAIL reset sideband: got %h want 0", sb_out());
    end
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_err++; $display("FAIL post_reset ready_o: got %b want 1", ready_o);
    end
  endtask

  task automatic test_alu_vectors();
    logic [31:0] va [3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h1};
    logic [31:0] vb [3] = '{32'h1, 32'h21, 32'hFFFF_FFFF};
    logic [3:0]  vo [3] = '{4'd0, 4'd3, 4'd9};
    logic [31:0] ve [3] = '{32'h8000_0000, 32'hC000_0000, 32'h1};
    logic [SBW-1:0] esb;
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], vo[i], 1'b0, 3'd0, 1'b0, 4'd0);
      esb = sb_in();
      tick();
      valid_i = 1'b0;
      n_cmp++;
      if (valid_o !== 1'b1 || result_o !== ve[i]) begin
        n_err++;
        $display("FAIL alu_vec[%0d]: got v=%b r=%h want v=1 r=%h",
                 i, valid_o, result_o, ve[i]);
      end
      n_cmp++;
      if (sb_out() !== esb) begin
        n_err++;
        $display("FAIL alu_vec[%0d] sideband: got %h want %h",
                 i, sb_out(), esb);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, exp;
    logic [3:0] op;
    logic trap;
    logic [SBW-1:0] esb;
    ready_i = 1'b1;
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      b = (i % 4 == 0) ? 32'($urandom_range(0, 70)) : $urandom;
      op = 4'($urandom_range(0, 15));
      trap = ($urandom_range(0, 7) == 0);
      issue(a, b, op, 1'b0, 3'd0, trap, 4'($urandom));
      exp = trap ? 32'd0 : ref_alu(op, a, b);
      esb = sb_in();
      n_cmp++;
      if (ready_o !== 1'b1) begin
        n_err++; $display("FAIL b2b[%0d] ready_o: got %b want 1", i, ready_o);
      end
      tick();
      n_cmp++;
      if (valid_o !== 1'b1 || result_o !== exp) begin
        n_err++;
        $display("FAIL b2b[%0d] op=%0d a=%h b=%h: got v=%b r=%h want r=%h",
                 i, op, a, b, valid_o, result_o, exp);
      end
      n_cmp++;
      if (sb_out() !== esb) begin
        n_err++;
        $display("FAIL b2b[%0d] sideband: got %h want %h", i, sb_out(), esb);
      end
    end
    @(negedge clk);
    valid_i = 1'b0;
    tick();
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_err++; $display("FAIL b2b drain valid_o: got %b want 0", valid_o);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ea, eb;
    logic [SBW-1:0] sa, sbb;
    ready_i = 1'b0;
    issue(32'd100, 32'd23, 4'd2, 1'b0, 3'd0, 1'b0, 4'd0);
    ea = 32'd77;
    sa = sb_in();
    tick();
    issue(32'hF0F0_0000, 32'h0F0F_1234, 4'd6, 1'b0, 3'd0, 1'b0, 4'd0);
    eb = 32'hFFFF_1234;
    sbb = sb_in();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (valid_o !== 1'b1 || result_o !== ea || sb_out() !== sa) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got v=%b r=%h want v=1 r=%h",
                 i, valid_o, result_o, ea);
      end
      n_cmp++;
      if (ready_o !== 1'b0) begin
        n_err++; $display("FAIL bp_hold[%0d] ready_o: got %b want 0", i, ready_o);
      end
    end
    @(negedge clk);
    ready_i = 1'b1;
    #1;
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_err++; $display("FAIL bp_release ready_o: got %b want 1", ready_o);
    end
    tick();
    valid_i = 1'b0;
    n_cmp++;
    if (valid_o !== 1'b1 || result_o !== eb || sb_out() !== sbb) begin
      n_err++;
      $display("FAIL bp_next: got v=%b r=%h want v=1 r=%h", valid_o, result_o, eb);
    end
    tick();
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_err++; $display("FAIL bp_empty valid_o: got %b want 0", valid_o);
    end
  endtask

  task automatic test_flush();
    ready_i = 1'b0;
    issue(32'd9, 32'd9, 4'd0, 1'b0, 3'd0, 1'b0, 4'd0);
    tick();
    issue(32'd1, 32'd1, 4'd0, 1'b0, 3'd0, 1'b0, 4'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    n_cmp++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL flush: got v=%b rdy=%b want v=0 rdy=1", valid_o, ready_o);
    end
    ready_i = 1'b1;
    issue(32'd2, 32'd3, 4'd0, 1'b0, 3'd0, 1'b0, 4'd0);
    tick();
    valid_i = 1'b0;
    n_cmp++;
    if (valid_o !== 1'b1 || result_o !== 32'd5) begin
      n_err++;
      $display("FAIL flush_add: got v=%b r=%h want v=1 r=5", valid_o, result_o);
    end
    tick();
  endtask

`ifndef MORTY_EX_MULDIV_EN
  task automatic test_no_muldiv();
    logic [SBW-1:0] esb;
    logic [3:0] tc;
    logic trap;
    ready_i = 1'b1;
    issue(32'd3, 32'd4, 4'd0, 1'b1, 3'd0, 1'b0, 4'd0);
    tick();
    valid_i = 1'b0;
    n_cmp++;
    if (valid_o !== 1'b1 || is_trap_o !== 1'b1 || trap_code_o !== 4'd2
        || result_o !== '0) begin
      n_err++;
      $display("FAIL nomd_mul: got v=%b t=%b c=%0d r=%h want 1 1 2 0",
               valid_o, is_trap_o, trap_code_o, result_o);
    end
    issue(32'd3, 32'd4, 4'd0, 1'b1, 3'd0, 1'b1, 4'd5);
    tick();
    valid_i = 1'b0;
    n_cmp++;
    if (is_trap_o !== 1'b1 || trap_code_o !== 4'd5 || result_o !== '0) begin
      n_err++;
      $display("FAIL nomd_trap: got t=%b c=%0d r=%h want 1 5 0",
               is_trap_o, trap_code_o, result_o);
    end
    for (int i = 0; i < 30; i++) begin
      trap = 1'($urandom);
      tc = 4'($urandom);
      issue($urandom, $urandom, 4'($urandom), 1'b1, 3'($urandom), trap, tc);
      esb = {pc_i, pc4_i, rd_i, csr_data_i, csr_addr_i, rs2_data_i,
             trap ? tc : 4'd2, 1'b1, is_rs0_i};
      tick();
      n_cmp++;
      if (valid_o !== 1'b1 || result_o !== '0 || sb_out() !== esb) begin
        n_err++;
        $display("FAIL nomd_rand[%0d]: got v=%b r=%h sb=%h want sb=%h",
                 i, valid_o, result_o, sb_out(), esb);
      end
    end
    @(negedge clk);
    valid_i = 1'b0;
    tick();
  endtask
`else
  task automatic test_muldiv_vectors();
    logic [2:0]  vo [7] = '{3'd1, 3'd3, 3'd4, 3'd6, 3'd4, 3'd6, 3'd6};
    logic [31:0] va [7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd5, 32'd5,
                            32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] vb [7] = '{32'h8000_0000, 32'd2, 32'd0, 32'd0,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
    logic [31:0] ve [7] = '{32'h4000_0000, 32'd1, 32'hFFFF_FFFF, 32'd5,
                            32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
    logic [SBW-1:0] esb;
    int cyc;
    bit rb;
    ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      issue(va[i], vb[i], 4'd0, 1'b1, vo[i], 1'b0, 4'd0);
      esb = sb_in();
      tick();
      valid_i = 1'b0;
      wait_valid(cyc, rb);
      n_cmp++;
      if (cyc != 33 || rb) begin
        n_err++;
        $display("FAIL md_vec[%0d] timing: got lat=%0d rdy_busy=%b want 33 0",
                 i, cyc, rb);
      end
      n_cmp++;
      if (valid_o !== 1'b1 || result_o !== ve[i] || sb_out() !== esb) begin
        n_err++;
        $display("FAIL md_vec[%0d]: got v=%b r=%h want r=%h",
                 i, valid_o, result_o, ve[i]);
      end
      tick();
    end
  endtask

  task automatic test_muldiv_random();
    logic [31:0] a, b, exp;
    logic [2:0] op;
    int cyc;
    bit rb;
    ready_i = 1'b1;
    for (int i = 0; i < 24; i++) begin
      op = 3'(i % 8);
      a = $urandom;
      b = (i % 6 == 5) ? 32'($urandom_range(0, 3)) : $urandom;
      issue(a, b, 4'd0, 1'b1, op, 1'b0, 4'd0);
      exp = ref_md(op, a, b);
      tick();
      valid_i = 1'b0;
      wait_valid(cyc, rb);
      n_cmp++;
      if (valid_o !== 1'b1 || result_o !== exp) begin
        n_err++;
        $display("FAIL md_rand[%0d] op=%0d a=%h b=%h: got %h want %h",
                 i, op, a, b, result_o, exp);
      end
      tick();
    end
  endtask

  task automatic test_muldiv_backpressure();
    logic [SBW-1:0] esb;
    int cyc;
    bit rb;
    ready_i = 1'b0;
    issue(32'd100, 32'd7, 4'd0, 1'b1, 3'd5, 1'b0, 4'd0);
    esb = sb_in();
    tick();
    valid_i = 1'b0;
    wait_valid(cyc, rb);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (valid_o !== 1'b1 || result_o !== 32'd14 || sb_out() !== esb
          || ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL md_bp[%0d]: got v=%b r=%h rdy=%b want v=1 r=e rdy=0",
                 i, valid_o, result_o, ready_o);
      end
      tick();
    end
    @(negedge clk);
    ready_i = 1'b1;
    tick();
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_err++; $display("FAIL md_bp drain: got v=%b want 0", valid_o);
    end
  endtask

  task automatic test_muldiv_flush();
    bit stale;
    ready_i = 1'b1;
    issue(32'd1000, 32'd3, 4'd0, 1'b1, 3'd4, 1'b0, 4'd0);
    tick();
    valid_i = 1'b0;
    repeat (9) tick();
    @(negedge clk);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    n_cmp++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL md_flush: got v=%b rdy=%b want v=0 rdy=1", valid_o, ready_o);
    end
    issue(32'd2, 32'd3, 4'd0, 1'b0, 3'd0, 1'b0, 4'd0);
    tick();
    valid_i = 1'b0;
    n_cmp++;
    if (valid_o !== 1'b1 || result_o !== 32'd5) begin
      n_err++;
      $display("FAIL md_flush_add: got v=%b r=%h want v=1 r=5", valid_o, result_o);
    end
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid_o !== 1'b0) stale = 1'b1;
    end
    n_cmp++;
    if (stale) begin
      n_err++; $display("FAIL md_flush_stale: got stale valid_o want none");
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_vectors();
    test_back_to_back();
    test_backpressure();
    test_flush();
`ifndef MORTY_EX_MULDIV_EN
    test_no_muldiv();
`else
    test_muldiv_vectors();
    test_muldiv_random();
    test_muldiv_backpressure();
    test_muldiv_flush();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
- Registered, parametrised successor of the combinational execute stage.
- Adds an XLEN-generic ALU with SLT/SLTU and masked shift amounts.
- Adds an iterative RV-M multiply/divide unit and valid/ready handshakes on both sides, so EX can stall for multi-cycle ops and respect MEM backpressure.
- Sits between the ID/EX and EX/MEM boundaries; sideband fields pass through with the result.

Parameters:
- XLEN, 32: datapath width; must be a power of two, 32 or 64.
- SHW, $clog2(XLEN): shift-amount width; derived, do not override.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  kill the in-flight op and the output register
- valid_i  in  1  input op valid
- ready_o  out  1  stage can accept an op this cycle
- src_a_i  in  XLEN  operand A
- src_b_i  in  XLEN  operand B
- alu_op_i  in  4  ALU op: 0 add, 1 sll, 2 sub, 3 sra, 4 xor, 5 srl, 6 or, 7 and, 8 slt, 9 sltu; 10-15 reserved, result 0
- is_md_i  in  1  op is RV-M; selects md_op_i and ignores alu_op_i
- md_op_i  in  3  RV funct3: mul, mulh, mulhsu, mulhu, div, divu, rem, remu
- pc_i, pc4_i  in  XLEN  pass-through
- rd_i  in  5  pass-through
- csr_data_i  in  XLEN  pass-through
- csr_addr_i  in  12  pass-through
- rs2_data_i  in  XLEN  pass-through
- trap_code_i  in  4  pass-through
- is_trap_i  in  1  pass-through
- is_rs0_i  in  1  pass-through
- valid_o  out  1  output register holds a result
- ready_i  in  1  MEM accepts the output this cycle
- result_o  out  XLEN  ALU/MDU result
- pc_o, pc4_o, rd_o, csr_data_o, csr_addr_o, rs2_data_o, trap_code_o, is_trap_o, is_rs0_o  out  (as inputs)  registered copies of the sideband inputs

Behaviour:
- Reset (async, rst_ni=0): all outputs 0, including valid_o; FSM returns to IDLE; MDU counter cleared. Reset mid-MD-op abandons the op.
- Handshake:
  - Input transfer occurs when valid_i && ready_o.
  - Output transfer occurs when valid_o && ready_i.
  - ready_o = (state==IDLE) && (!valid_o || ready_i).
  - Output register and all _o fields are stable while valid_o && !ready_i.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, ALU op or is_trap_i: compute combinationally and load the output register next edge (1-cycle latency); stay in IDLE.
  - IDLE, MD op (!is_trap_i): latch operands and sideband; counter=XLEN; go to BUSY.
  - BUSY: one iteration per cycle (shift-add multiply, restoring divide) and decrement the counter. At 0, go to DONE.
  - DONE: load the output register when !valid_o || ready_i, then return to IDLE. Otherwise hold.
  - MD latency from accept to valid_o is XLEN+1 cycles with no backpressure.
- Arithmetic:
  - Shifts use src_b_i[SHW-1:0]; sra is arithmetic; slt is signed; sltu is unsigned.
  - All add/sub wrap modulo 2^XLEN.
  - mul returns low XLEN bits; mulh/mulhsu/mulhu return high XLEN bits of the 2·XLEN product with the named signedness.
  - Divide by zero: quotient all-ones; remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend; remainder 0.
  - div/rem truncate toward zero; remainder takes the sign of the dividend.
- Trap ops are never started in the MDU; result_o = 0 and sideband passes through.
- flush_i has priority over everything except reset. Next edge: valid_o=0, state=IDLE, and any same-cycle input is dropped (ready_o is still computed normally, but the transfer is discarded).
- Simultaneous output drain and new accept is legal; full throughput is 1 ALU op/cycle.

Optional Feature:
- MORTY_EX_MULDIV_EN
- Defined: MDU is instantiated and behaves as above.
- Undefined:
  - No MDU logic; FSM reduces to IDLE.
  - An MD op is accepted with 1-cycle latency and emitted with is_trap_o=1, trap_code_o=4'd2 (illegal instruction), result_o=0.
  - If is_trap_i is already set, the original trap code is kept.

Decomposition:
- Package morty_ex_pkg holds:
  - ALU op localparams (ALU_ADD..ALU_SLTU).
  - MD funct3 localparams (MD_MUL..MD_REMU).
  - FSM state typedef/localparams (EX_IDLE, EX_BUSY, EX_DONE).
  - TRAP_ILLEGAL=4'd2.
- One sub-module, ex_muldiv:
  - Ports: start, operands, op, done, result.
  - Contains the iteration counter, the sign-fixup logic and the divide corner cases.

Test Plan:
- XLEN=32 ALU sweep: add 0x7FFFFFFF+1 -> 0x80000000; sra 0x80000000 by 0x21 -> 0xC0000000 (amount masked to 1); sltu 1 vs 0xFFFFFFFF -> 1; each with 1-cycle latency.
- mulh 0x80000000 × 0x80000000 -> 0x40000000; mulhu 0xFFFFFFFF × 2 -> 1; valid_o exactly 33 cycles after accept; ready_o=0 throughout BUSY.
- div 5/0 -> 0xFFFFFFFF; rem 5/0 -> 5; div 0x80000000 / 0xFFFFFFFF -> 0x80000000; rem of the same -> 0; rem -7/2 -> 0xFFFFFFFF (-1).
- Backpressure: hold ready_i=0 with valid_o=1 -> all outputs stable; MD finishing meanwhile waits in DONE; raising ready_i drains it, then the MD result appears the next cycle.
- flush_i asserted mid-BUSY (cycle 10 of a div) -> next cycle valid_o=0, ready_o=1; a following add 2+3 returns 5 with no stale MD data.
- Macro undefined: mul 3×4 -> is_trap_o=1, trap_code_o=2, result_o=0 after 1 cycle; with is_trap_i=1, trap_code_i=5 -> trap_code_o=5.
